// File: rtl/meta_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : meta_port_arbiter
// Description : Arbitrates three read requesters (CPU, probe, refill) and two
//               write requesters (refill, probe) onto a single-port metadata
//               array. It gives writes fixed priority and reads round-robin
//               order, blocks writes while reads are starved, and returns a
//               one-cycle response with a tag/coherence hit check.
// Revision    : 1.0 - initial release
// ============================================================================
module meta_port_arbiter #(
    parameter int IDX_W      = 7,
    parameter int TAG_W      = 19,
    parameter int STARVE_LIM = 4
) (
    input  logic             clk,
    input  logic             reset,

    // read requesters: 0 = CPU, 1 = probe, 2 = refill
    input  logic             rd_valid_0,
    output logic             rd_ready_0,
    input  logic [IDX_W-1:0] rd_idx_0,
    input  logic [TAG_W-1:0] rd_tag_0,
    input  logic             rd_valid_1,
    output logic             rd_ready_1,
    input  logic [IDX_W-1:0] rd_idx_1,
    input  logic [TAG_W-1:0] rd_tag_1,
    input  logic             rd_valid_2,
    output logic             rd_ready_2,
    input  logic [IDX_W-1:0] rd_idx_2,
    input  logic [TAG_W-1:0] rd_tag_2,

    // write requesters: 0 = refill, 1 = probe
    input  logic             wr_valid_0,
    output logic             wr_ready_0,
    input  logic [IDX_W-1:0] wr_idx_0,
    input  logic [TAG_W-1:0] wr_tag_0,
    input  logic [1:0]       wr_coh_0,
    input  logic             wr_valid_1,
    output logic             wr_ready_1,
    input  logic [IDX_W-1:0] wr_idx_1,
    input  logic [TAG_W-1:0] wr_tag_1,
    input  logic [1:0]       wr_coh_1,

    // single-port metadata array
    output logic             arr_read_valid,
    output logic [IDX_W-1:0] arr_read_idx,
    input  logic             arr_read_ready,
    output logic             arr_write_valid,
    output logic [IDX_W-1:0] arr_write_idx,
    output logic [TAG_W-1:0] arr_write_tag,
    output logic [1:0]       arr_write_coh,
    input  logic             arr_write_ready,
    input  logic [TAG_W-1:0] arr_resp_tag,
    input  logic [1:0]       arr_resp_coh,

    // per-requester responses
    output logic             resp_valid_0,
    output logic             resp_hit_0,
    output logic [TAG_W-1:0] resp_tag_0,
    output logic [1:0]       resp_coh_0,
    output logic             resp_valid_1,
    output logic             resp_hit_1,
    output logic [TAG_W-1:0] resp_tag_1,
    output logic [1:0]       resp_coh_1,
    output logic             resp_valid_2,
    output logic             resp_hit_2,
    output logic [TAG_W-1:0] resp_tag_2,
    output logic [1:0]       resp_coh_2,

    output logic             init_done
);

    localparam logic [3:0] c_CNT_MAX    = 4'd15;
    localparam logic [3:0] c_STARVE_LIM = 4'(STARVE_LIM);

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_BLOCK_WR = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_init_done;
    logic [1:0]       r_rr_ptr;
    logic [3:0]       r_starve;
    logic             r_pend;
    logic [1:0]       r_owner;
    logic [TAG_W-1:0] r_ctag;

    logic [2:0]       w_rd_valid;
    logic             w_rd_any;
    logic             w_live;
    logic             w_wr_issue;
    logic             w_rd_issue;
    logic             w_rd_fire;
    logic [1:0]       w_rd_sel;
    logic [1:0]       w_rd_sel_next;
    logic [TAG_W-1:0] w_rd_tag_sel;
    logic [3:0]       w_starve_next;
    logic             w_resp_live;
    logic             w_resp_hit;

    // Round-robin pick: search starts at ptr and wraps modulo 3.
    function automatic logic [1:0] f_rr_pick(input logic [1:0] ptr, input logic [2:0] v);
        logic [1:0] first;
        logic [1:0] second;
        logic [1:0] third;
        first  = (ptr > 2'd2) ? 2'd0 : ptr;
        second = (first == 2'd2) ? 2'd0 : first + 2'd1;
        third  = (second == 2'd2) ? 2'd0 : second + 2'd1;
        if (v[first])
            return first;
        else if (v[second])
            return second;
        else
            return third;
    endfunction

    assign w_rd_valid = {rd_valid_2, rd_valid_1, rd_valid_0};
    assign w_rd_any   = |w_rd_valid;

    // Nothing is offered to the array while in INIT or while reset is held.
    assign w_live = ~reset & (r_state != ST_INIT);

    // ---------------------------------------------------------------- writes
    // Writes go out only in RUN; wr_0 always beats wr_1.
    assign w_wr_issue      = w_live & (r_state == ST_RUN) & (wr_valid_0 | wr_valid_1);
    assign arr_write_valid = w_wr_issue;
    assign wr_ready_0      = w_wr_issue & arr_write_ready & wr_valid_0;
    assign wr_ready_1      = w_wr_issue & arr_write_ready & ~wr_valid_0 & wr_valid_1;
    assign arr_write_idx   = wr_valid_0 ? wr_idx_0 : wr_idx_1;
    assign arr_write_tag   = wr_valid_0 ? wr_tag_0 : wr_tag_1;
    assign arr_write_coh   = wr_valid_0 ? wr_coh_0 : wr_coh_1;

    // ----------------------------------------------------------------- reads
    // A read is presented only in cycles without an issued write, which keeps
    // the two array strobes mutually exclusive.
    assign w_rd_sel       = f_rr_pick(r_rr_ptr, w_rd_valid);
    assign w_rd_issue     = w_live & ~w_wr_issue & w_rd_any;
    assign w_rd_fire      = w_rd_issue & arr_read_ready;
    assign arr_read_valid = w_rd_issue;
    assign rd_ready_0     = w_rd_fire & (w_rd_sel == 2'd0);
    assign rd_ready_1     = w_rd_fire & (w_rd_sel == 2'd1);
    assign rd_ready_2     = w_rd_fire & (w_rd_sel == 2'd2);
    assign w_rd_sel_next  = (w_rd_sel == 2'd2) ? 2'd0 : w_rd_sel + 2'd1;

    // Route the winner's index and tag.
    always_comb begin
        arr_read_idx = rd_idx_0;
        w_rd_tag_sel = rd_tag_0;
        case (w_rd_sel)
            2'd1: begin
                arr_read_idx = rd_idx_1;
                w_rd_tag_sel = rd_tag_1;
            end
            2'd2: begin
                arr_read_idx = rd_idx_2;
                w_rd_tag_sel = rd_tag_2;
            end
            default: begin
                arr_read_idx = rd_idx_0;
                w_rd_tag_sel = rd_tag_0;
            end
        endcase
    end

    // Starvation count: any pending read that does not fire adds one, saturating.
    always_comb begin
        w_starve_next = r_starve;
        if (w_rd_fire)
            w_starve_next = 4'd0;
        else if (w_rd_any && (r_starve != c_CNT_MAX))
            w_starve_next = r_starve + 4'd1;
    end

    // Round-robin pointer and starvation counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= 2'd0;
            r_starve <= 4'd0;
        end else begin
            r_starve <= w_starve_next;
            if (w_rd_fire)
                r_rr_ptr <= w_rd_sel_next;
        end
    end

    // Control FSM: INIT waits for the array, BLOCK_WR lets starved reads through.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_INIT;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (arr_write_ready) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_init_done <= 1'b1;
                    if (w_starve_next >= c_STARVE_LIM)
                        r_state <= ST_BLOCK_WR;
                end
                ST_BLOCK_WR: begin
                    r_init_done <= 1'b1;
                    if (w_rd_fire || !w_rd_any)
                        r_state <= ST_RUN;
                end
                default: begin
                    r_state     <= ST_INIT;
                    r_init_done <= 1'b0;
                end
            endcase
        end
    end

    assign init_done = r_init_done;

    // Response pipeline: remember who fired and which tag to compare against.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend  <= 1'b0;
            r_owner <= 2'd0;
            r_ctag  <= '0;
        end else begin
            r_pend <= w_rd_fire;
            if (w_rd_fire) begin
                r_owner <= w_rd_sel;
                r_ctag  <= w_rd_tag_sel;
            end
        end
    end

    // Responses are suppressed while reset is held so a dropped read never surfaces.
    assign w_resp_live = r_pend & ~reset;
    assign w_resp_hit  = (arr_resp_tag == r_ctag) & (arr_resp_coh != 2'd0);

    assign resp_valid_0 = w_resp_live & (r_owner == 2'd0);
    assign resp_valid_1 = w_resp_live & (r_owner == 2'd1);
    assign resp_valid_2 = w_resp_live & (r_owner == 2'd2);

    assign resp_hit_0 = resp_valid_0 & w_resp_hit;
    assign resp_hit_1 = resp_valid_1 & w_resp_hit;
    assign resp_hit_2 = resp_valid_2 & w_resp_hit;

    assign resp_tag_0 = resp_valid_0 ? arr_resp_tag : '0;
    assign resp_tag_1 = resp_valid_1 ? arr_resp_tag : '0;
    assign resp_tag_2 = resp_valid_2 ? arr_resp_tag : '0;

    assign resp_coh_0 = resp_valid_0 ? arr_resp_coh : 2'd0;
    assign resp_coh_1 = resp_valid_1 ? arr_resp_coh : 2'd0;
    assign resp_coh_2 = resp_valid_2 ? arr_resp_coh : 2'd0;

endmodule
`default_nettype wire

// File: doc/meta_port_arbiter.md
META_PORT_ARBITER -- requirements
Module: meta_port_arbiter

Interface
REQ-001 Parameter IDX_W, default 7: metadata set-index width.
REQ-002 Parameter TAG_W, default 19: metadata tag width.
REQ-003 Parameter STARVE_LIM, default 4: consecutive denied read cycles before write blocking; legal range 1..15.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 Ports rd_valid_i / rd_ready_i, i=0..2, in/out, 1 each: read requests; 0 = CPU, 1 = probe, 2 = refill.
REQ-007 Ports rd_idx_i (IDX_W) and rd_tag_i (TAG_W), i=0..2, inputs: set index and compare tag for each read request.
REQ-008 Ports wr_valid_j / wr_ready_j, j=0..1, in/out, 1 each: write requests; 0 = refill, 1 = probe.
REQ-009 Ports wr_idx_j (IDX_W), wr_tag_j (TAG_W) and wr_coh_j (2), j=0..1, inputs: write payload.
REQ-010 Ports arr_read_valid, arr_read_idx, arr_read_ready (in), arr_write_valid, arr_write_idx, arr_write_tag, arr_write_coh and arr_write_ready (in): the single-port metadata array interface.
REQ-011 Ports arr_resp_tag (TAG_W) and arr_resp_coh (2), inputs: array read data, valid in the cycle after a read fire.
REQ-012 Ports resp_valid_i, resp_hit_i, resp_tag_i and resp_coh_i, i=0..2, outputs: per-requester response.
REQ-013 Port init_done, output, 1: high once the array has completed its reset sweep.

Function
REQ-014 A read fire is arr_read_valid & arr_read_ready; a write fire is arr_write_valid & arr_write_ready; a requester handshake completes only when its valid and ready are both high.
REQ-015 Writes: at most one per cycle; wr_0 has priority over wr_1; wr_ready_j is combinational and high only for the selected requester, and only when arr_write_ready=1 and the block is not in BLOCK_WR.
REQ-016 Reads: at most one per cycle; selection is round-robin among rd_0..2, starting from the index after the last read-fire winner; the pointer resets to rd_0 first.
REQ-017 Read grants are offered only when no write is issued in that cycle and arr_read_ready=1; rd_ready_i is high only for the selected requester.
REQ-018 arr_read_valid and arr_write_valid are never high in the same cycle.
REQ-019 Starvation counter: increments (saturating at 15) in each cycle where any rd_valid is high and no read fires; clears on every read fire.
REQ-020 The block has three states:
- RUN: normal operation.
- BLOCK_WR: entered from RUN when the starvation counter reaches STARVE_LIM; all write grants are suppressed; returns to RUN in the cycle after a read fire, or when all rd_valid drop.
- INIT: the reset state; init_done=0; exits to RUN on the first cycle arr_write_ready=1.
REQ-021 In INIT, all rd_ready and wr_ready outputs are 0.
REQ-022 Response pipeline: on a read fire, the block registers owner id, compare tag and a pending bit.
REQ-023 In the following cycle, resp_valid_owner=1 for exactly one cycle, with resp_tag=arr_resp_tag and resp_coh=arr_resp_coh.
REQ-024 resp_hit = (arr_resp_tag == captured tag) & (arr_resp_coh != 0).
REQ-025 Latency from read fire to response: exactly 1 cycle; back-to-back read fires give back-to-back responses.
REQ-026 A write fire in the response cycle does not alter that cycle's response data.
REQ-027 Response outputs are zero whenever resp_valid is 0.

Reset
REQ-028 On reset, the block enters INIT.
REQ-029 On reset, the round-robin pointer, starvation counter and pending bit clear.
REQ-030 On reset, all ready, valid and response outputs are 0, and init_done=0.
REQ-031 Reset asserted mid-operation drops any pending response; no resp_valid is asserted in the cycle after reset.

Verification
REQ-032 Reset, then hold arr_write_ready=0 for 128 cycles while rd_valid_0=1 -> rd_ready_0=0 throughout; init_done rises the cycle after arr_write_ready=1.
REQ-033 rd_valid_0..2 all high continuously, no writes -> read grants cycle 0,1,2,0,1,2 and each resp_valid follows its grant by 1 cycle.
REQ-034 wr_valid_0 and wr_valid_1 both high -> wr_0 granted first; wr_1 granted the following cycle; no read fire in either cycle.
REQ-035 STARVE_LIM=4, wr_valid_0 held high, rd_valid_1 high -> 4 write fires, then no write grant and rd_1 fires in cycle 5; writes resume in cycle 6.
REQ-036 Read with rd_tag=19'h1A2B3, next-cycle arr_resp_tag=19'h1A2B3 and coh=2'h2 -> resp_hit=1; same case with coh=0 -> resp_hit=0.
REQ-037 Reset asserted in the cycle after a read fire -> no resp_valid; all readies are 0 in the next cycle.
